// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipe_fwd_chain pipeline register chain.
// Holds the default register-address width, the forward-select width helper
// and the per-stage control tuple type.
package pipe_pkg;

  // Default register address width (32 architectural registers).
  localparam int PIPE_AW = 5;

  // Forward select encodes 0 = register file, j+1 = stage j.
  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // Control part of one pipeline stage.
  typedef struct packed {
    logic               valid;
    logic               wr_en;
    logic [PIPE_AW-1:0] rd;
  } stage_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage register {valid, wr_en, rd, payload}.
// Per-edge priority: flush squashes, hold keeps, an upstream hold inserts a
// bubble, otherwise the stage loads. Flush and bubble keep rd/payload.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = PIPE_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic             up_hold_i,
  input  logic             ld_valid_i,
  input  logic             ld_wr_en_i,
  input  logic [AW-1:0]    ld_rd_i,
  input  logic [WIDTH-1:0] ld_payload_i,
  output logic             valid_o,
  output logic             wr_en_o,
  output logic [AW-1:0]    rd_o,
  output logic [WIDTH-1:0] payload_o
);

  logic             valid_q, valid_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] payload_q, payload_d;

  // Next-state selection: flush > hold > bubble > load.
  always_comb begin
    valid_d   = valid_q;
    wr_en_d   = wr_en_q;
    rd_d      = rd_q;
    payload_d = payload_q;
    if (flush_i) begin
      valid_d = 1'b0;
      wr_en_d = 1'b0;
    end else if (!hold_i) begin
      if (up_hold_i) begin
        valid_d = 1'b0;
        wr_en_d = 1'b0;
      end else begin
        valid_d   = ld_valid_i;
        wr_en_d   = ld_wr_en_i;
        rd_d      = ld_rd_i;
        payload_d = ld_payload_i;
      end
    end
  end

  // Stage register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_q      <= '0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      wr_en_q   <= wr_en_d;
      rd_q      <= rd_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign wr_en_o   = wr_en_q;
  assign rd_o      = rd_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/pipe_fwd_chain.sv
// pipe_fwd_chain: STAGES-deep in-order register chain with stall/flush
// sequencing, destination tracking and operand forward/hazard detection.
// Optional feature macro PIPE_FWD_EN: when defined, ready stages forward their
// result; when undefined, any in-flight match raises hazard and nothing is
// forwarded.
module pipe_fwd_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DW          = 32,
  parameter int STAGES      = 3,
  parameter int NSRC        = 2,
  parameter int AW          = PIPE_AW,
  parameter int READY_STAGE = 1,
  parameter int SELW        = sel_width(STAGES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_wr_en,
  input  logic [AW-1:0]           in_rd,
  input  logic [WIDTH-1:0]        in_payload,
  input  logic [STAGES*WIDTH-1:0] upd_payload,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic [NSRC*AW-1:0]      src_addr,
  output logic [NSRC*SELW-1:0]    fwd_sel,
  output logic [NSRC*DW-1:0]      fwd_data,
  output logic                    hazard,
  output logic [STAGES-1:0]       stage_valid,
  output logic                    out_valid,
  output logic                    out_wr_en,
  output logic [AW-1:0]           out_rd,
  output logic [WIDTH-1:0]        out_payload
);

  // Effective hold propagates from older stages back toward stage 0.
  logic [STAGES:0]                 hold;
  logic [STAGES-1:0]               st_valid;
  logic [STAGES-1:0]               st_wr_en;
  logic [STAGES-1:0][AW-1:0]       st_rd;
  logic [STAGES-1:0][WIDTH-1:0]    st_pay;

  assign hold[STAGES] = 1'b0;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      assign hold[gi] = stall[gi] | hold[gi+1];
      if (gi == 0) begin : g_first
        pipe_stage_reg #(.WIDTH(WIDTH), .AW(AW)) u_reg (
          .clk          (clk),
          .rst          (rst),
          .flush_i      (flush[gi]),
          .hold_i       (hold[gi]),
          .up_hold_i    (1'b0),
          .ld_valid_i   (in_valid),
          .ld_wr_en_i   (in_wr_en),
          .ld_rd_i      (in_rd),
          .ld_payload_i (in_payload),
          .valid_o      (st_valid[gi]),
          .wr_en_o      (st_wr_en[gi]),
          .rd_o         (st_rd[gi]),
          .payload_o    (st_pay[gi])
        );
      end else begin : g_next
        pipe_stage_reg #(.WIDTH(WIDTH), .AW(AW)) u_reg (
          .clk          (clk),
          .rst          (rst),
          .flush_i      (flush[gi]),
          .hold_i       (hold[gi]),
          .up_hold_i    (hold[gi-1]),
          .ld_valid_i   (st_valid[gi-1]),
          .ld_wr_en_i   (st_wr_en[gi-1]),
          .ld_rd_i      (st_rd[gi-1]),
          .ld_payload_i (upd_payload[gi*WIDTH +: WIDTH]),
          .valid_o      (st_valid[gi]),
          .wr_en_o      (st_wr_en[gi]),
          .rd_o         (st_rd[gi]),
          .payload_o    (st_pay[gi])
        );
      end
    end
  endgenerate

  // Writeback port and valid vector come straight from the stage registers.
  assign stage_valid = st_valid;
  assign out_valid   = st_valid[STAGES-1];
  assign out_wr_en   = st_wr_en[STAGES-1];
  assign out_rd      = st_rd[STAGES-1];
  assign out_payload = st_pay[STAGES-1];

  // Slice 0 of upd_payload and the non-forwarded payload bits have no reader.
  logic unused_ok;
  assign unused_ok = ^{upd_payload[WIDTH-1:0], st_pay, 32'(READY_STAGE)};

  logic [AW-1:0]   src;
  logic            hit;
`ifdef PIPE_FWD_EN
  logic            hit_ready;
  logic [SELW-1:0] hit_sel;
  logic [DW-1:0]   hit_data;
`endif

  // Per source: find the youngest matching stage, then forward or flag hazard.
  always_comb begin
    fwd_sel   = '0;
    fwd_data  = '0;
    hazard    = 1'b0;
    src       = '0;
    hit       = 1'b0;
`ifdef PIPE_FWD_EN
    hit_ready = 1'b0;
    hit_sel   = '0;
    hit_data  = '0;
`endif
    for (int s = 0; s < NSRC; s++) begin
      src = src_addr[s*AW +: AW];
      hit = 1'b0;
`ifdef PIPE_FWD_EN
      hit_ready = 1'b0;
      hit_sel   = '0;
      hit_data  = '0;
`endif
      // Scan oldest to youngest so the youngest match is the last one kept.
      for (int j = STAGES - 1; j >= 0; j--) begin
        if (st_valid[j] && st_wr_en[j] && (st_rd[j] == src) && (src != '0)) begin
          hit = 1'b1;
`ifdef PIPE_FWD_EN
          hit_ready = (j >= READY_STAGE);
          hit_sel   = SELW'(j + 1);
          hit_data  = st_pay[j][DW-1:0];
`endif
        end
      end
`ifdef PIPE_FWD_EN
      if (hit) begin
        if (hit_ready) begin
          fwd_sel[s*SELW +: SELW] = hit_sel;
          fwd_data[s*DW +: DW]    = hit_data;
        end else begin
          hazard = 1'b1;
        end
      end
`else
      if (hit) begin
        hazard = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// tb_pipe_fwd_chain: directed test-plan sequences followed by randomized
// traffic, all compared every cycle against a stage-content reference model.
// Expectations follow PIPE_FWD_EN the same way the design does.
module tb_pipe_fwd_chain;
  import pipe_pkg::*;

  localparam int W    = 32;
  localparam int DW   = 16;
  localparam int S    = 3;
  localparam int NS   = 2;
  localparam int AW   = PIPE_AW;
  localparam int RS   = 1;
  localparam int SELW = sel_width(S);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_wr_en;
  logic [AW-1:0]     in_rd;
  logic [W-1:0]      in_payload;
  logic [S*W-1:0]    upd_payload;
  logic [S-1:0]      stall;
  logic [S-1:0]      flush;
  logic [NS*AW-1:0]  src_addr;
  logic [NS*SELW-1:0] fwd_sel;
  logic [NS*DW-1:0]  fwd_data;
  logic              hazard;
  logic [S-1:0]      stage_valid;
  logic              out_valid;
  logic              out_wr_en;
  logic [AW-1:0]     out_rd;
  logic [W-1:0]      out_payload;

  always #5 clk = ~clk;

  pipe_fwd_chain #(
    .WIDTH(W), .DW(DW), .STAGES(S), .NSRC(NS), .AW(AW), .READY_STAGE(RS), .SELW(SELW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_wr_en(in_wr_en), .in_rd(in_rd), .in_payload(in_payload),
    .upd_payload(upd_payload), .stall(stall), .flush(flush), .src_addr(src_addr),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .hazard(hazard), .stage_valid(stage_valid),
    .out_valid(out_valid), .out_wr_en(out_wr_en), .out_rd(out_rd), .out_payload(out_payload)
  );

  int chk_cnt  = 0;
  int fail_cnt = 0;

  // Reference model: contents of each stage.
  stage_t       m_st  [S];
  logic [W-1:0] m_pay [S];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one clock edge of the pipeline rules to the model.
  task automatic model_edge();
    logic [S:0]   h;
    stage_t       nst  [S];
    logic [W-1:0] npay [S];
    h[S] = 1'b0;
    for (int i = S - 1; i >= 0; i--) h[i] = stall[i] | h[i+1];
    for (int i = 0; i < S; i++) begin
      nst[i]  = m_st[i];
      npay[i] = m_pay[i];
      if (!rst) begin
        nst[i]  = '0;
        npay[i] = '0;
      end else if (flush[i]) begin
        nst[i].valid = 1'b0;
        nst[i].wr_en = 1'b0;
      end else if (!h[i]) begin
        if (i == 0) begin
          nst[0].valid = in_valid;
          nst[0].wr_en = in_wr_en;
          nst[0].rd    = in_rd;
          npay[0]      = in_payload;
        end else if (h[i-1]) begin
          nst[i].valid = 1'b0;
          nst[i].wr_en = 1'b0;
        end else begin
          nst[i]  = m_st[i-1];
          npay[i] = upd_payload[i*W +: W];
        end
      end
    end
    for (int i = 0; i < S; i++) begin
      m_st[i]  = nst[i];
      m_pay[i] = npay[i];
    end
  endtask

  // Compare every output against what the model implies.
  task automatic check_outputs(input string ph);
    logic [S-1:0] ev;
    for (int i = 0; i < S; i++) ev[i] = m_st[i].valid;
    chk({ph, ".stage_valid"}, 64'(stage_valid), 64'(ev));
    chk({ph, ".out_valid"}, 64'(out_valid), 64'(m_st[S-1].valid));
    chk({ph, ".out_wr_en"}, 64'(out_wr_en), 64'(m_st[S-1].wr_en));
    if (m_st[S-1].valid) begin
      chk({ph, ".out_rd"}, 64'(out_rd), 64'(m_st[S-1].rd));
      chk({ph, ".out_payload"}, 64'(out_payload), 64'(m_pay[S-1]));
    end
    begin
      logic          ehz;
      ehz = 1'b0;
      for (int s = 0; s < NS; s++) begin
        logic [AW-1:0]   a;
        int              found;
        logic [SELW-1:0] esel;
        logic [DW-1:0]   edata;
        a     = src_addr[s*AW +: AW];
        found = -1;
        esel  = '0;
        edata = '0;
        for (int j = 0; j < S; j++)
          if (found < 0 && m_st[j].valid && m_st[j].wr_en && m_st[j].rd == a && a != 0)
            found = j;
`ifdef PIPE_FWD_EN
        if (found >= RS) begin
          esel  = SELW'(found + 1);
          edata = m_pay[found][DW-1:0];
        end else if (found >= 0) begin
          ehz = 1'b1;
        end
`else
        if (found >= 0) ehz = 1'b1;
`endif
        chk($sformatf("%s.fwd_sel%0d", ph, s), 64'(fwd_sel[s*SELW +: SELW]), 64'(esel));
        chk($sformatf("%s.fwd_data%0d", ph, s), 64'(fwd_data[s*DW +: DW]), 64'(edata));
      end
      chk({ph, ".hazard"}, 64'(hazard), 64'(ehz));
    end
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(ph);
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_wr_en   = 1'b0;
    in_rd      = '0;
    in_payload = '0;
    stall      = '0;
    flush      = '0;
  endtask

  task automatic put(input logic [AW-1:0] rd, input logic [W-1:0] pay);
    in_valid   = 1'b1;
    in_wr_en   = 1'b1;
    in_rd      = rd;
    in_payload = pay;
  endtask

  localparam logic [W-1:0] U1 = 32'h1234_BEEF;
  localparam logic [W-1:0] U2 = 32'h5678_CAFE;

  initial begin
    for (int i = 0; i < S; i++) begin
      m_st[i]  = '0;
      m_pay[i] = '0;
    end
    rst = 1'b0;
    idle();
    upd_payload = '0;
    src_addr    = {5'd5, 5'd5};
    // Reset: everything zero, src_addr ignored.
    tick("rst");
    tick("rst");
    chk("rst.stage_valid0", 64'(stage_valid), 64'd0);
    chk("rst.out_payload0", 64'(out_payload), 64'd0);
    chk("rst.hazard0", 64'(hazard), 64'd0);
    rst = 1'b1;

    // Latency: payload carried unchanged through every stage.
    upd_payload = {S{32'h0000_00A5}};
    put(5'd5, 32'h0000_00A5);
    tick("lat");
    idle();
    tick("lat");
    chk("lat.early_valid", 64'(out_valid), 64'd0);
    tick("lat");
    chk("lat.out_valid", 64'(out_valid), 64'd1);
    chk("lat.out_rd", 64'(out_rd), 64'd5);
    chk("lat.out_payload", 64'(out_payload), 64'h0A5);
    tick("lat");

    // Forwarding / youngest-wins.
    upd_payload = {U2, U1, 32'h0};
    src_addr    = {5'd0, 5'd7};
    put(5'd7, 32'h1111_1111);
    tick("fwd");
    chk("fwd.s0_hazard", 64'(hazard), 64'd1);
    tick("fwd");
    idle();
    tick("fwd");
`ifdef PIPE_FWD_EN
    chk("fwd.youngest_sel", 64'(fwd_sel[SELW-1:0]), 64'd2);
    chk("fwd.youngest_data", 64'(fwd_data[DW-1:0]), 64'(U1[DW-1:0]));
`else
    chk("nofwd.hazard", 64'(hazard), 64'd1);
    chk("nofwd.sel", 64'(fwd_sel[SELW-1:0]), 64'd0);
`endif
    tick("fwd");
    tick("fwd");
    chk("fwd.drained_hazard", 64'(hazard), 64'd0);

    // One-cycle stall on stage 0 inserts a bubble into stage 1.
    put(5'd7, 32'h2222_2222);
    tick("stl");
    chk("stl.hazard", 64'(hazard), 64'd1);
    idle();
    stall = 3'b001;
    tick("stl");
    chk("stl.bubble", 64'(stage_valid), 64'b001);
    stall = 3'b000;
    tick("stl");
`ifdef PIPE_FWD_EN
    chk("stl.sel", 64'(fwd_sel[SELW-1:0]), 64'd2);
    chk("stl.hazard_clr", 64'(hazard), 64'd0);
`endif
    tick("stl");
    tick("stl");

    // Address 0 never matches.
    src_addr = '0;
    in_valid = 1'b1; in_wr_en = 1'b1; in_rd = '0; in_payload = 32'h3333_3333;
    tick("zero");
    idle();
    tick("zero");
    chk("zero.sel", 64'(fwd_sel), 64'd0);
    chk("zero.hazard", 64'(hazard), 64'd0);
    tick("zero");
    tick("zero");

    // Flush and stall together on stage 1.
    put(5'd9, 32'h4444_4444);
    tick("fls");
    put(5'd10, 32'h5555_5555);
    tick("fls");
    put(5'd11, 32'h6666_6666);
    flush = 3'b010;
    stall = 3'b010;
    src_addr = {5'd0, 5'd10};
    tick("fls");
    chk("fls.st1_valid", 64'(stage_valid[1]), 64'd0);
    chk("fls.st0_hold_hz", 64'(hazard), 64'd1);
    idle();
    tick("fls");
    tick("fls");
    tick("fls");

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(0, 99) != 0);
      in_valid    = $urandom_range(0, 3) != 0;
      in_wr_en    = $urandom_range(0, 3) != 0;
      in_rd       = AW'($urandom_range(0, 7));
      in_payload  = $urandom();
      upd_payload = {$urandom(), $urandom(), $urandom()};
      for (int i = 0; i < S; i++) begin
        stall[i] = ($urandom_range(0, 5) == 0);
        flush[i] = ($urandom_range(0, 9) == 0);
      end
      for (int s = 0; s < NS; s++) src_addr[s*AW +: AW] = AW'($urandom_range(0, 7));
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_fwd_chain.md
# pipe_fwd_chain

Parametrised in-order pipeline register chain with built-in stall/flush sequencing, destination-register tracking and operand forwarding/hazard detection. It is the successor of the fixed Execute/Memory/Writeback register set and its external forwarding muxes. It replaces hand-wired per-stage flops with STAGES generic stages and computes forward selects and hazard requests for NSRC source operands. It sits between decode and the register-file write port of the core.

## Interface
- WIDTH, 32: payload bits carried per stage (result value in bits [DW-1:0])
- DW, 32: forwardable result width, DW <= WIDTH
- STAGES, 3: number of register stages (>= 2); stage 0 youngest, STAGES-1 is writeback
- NSRC, 2: number of source operands checked
- AW, 5: register address width
- READY_STAGE, 1: first stage index whose result is valid for forwarding
- SELW, $clog2(STAGES+1): forward-select width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  instruction entering stage 0
- in_wr_en  in  1  instruction writes a register
- in_rd  in  AW  destination register
- in_payload  in  WIDTH  stage-0 payload
- upd_payload  in  STAGES*WIDTH  next payload per stage i>0 (datapath result of stage i-1)
- stall  in  STAGES  per-stage hold request
- flush  in  STAGES  per-stage squash request
- src_addr  in  NSRC*AW  source register addresses (decode)
- fwd_sel  out  NSRC*SELW  0 = register file; j+1 = take stage j
- fwd_data  out  NSRC*DW  selected forwarded value (0 when fwd_sel = 0)
- hazard  out  1  a source matches an unready stage; upstream must stall
- stage_valid  out  STAGES  valid bit per stage
- out_valid / out_wr_en / out_rd / out_payload  out  1/1/AW/WIDTH  stage STAGES-1 contents (register-file write port)

## Operation
- Each stage holds {valid, wr_en, rd, payload}. Stage 0 loads the in_* inputs. Stage i>0 loads stage i-1's valid/wr_en/rd and upd_payload slice i.
- Effective hold: hold[i] = stall[i] | hold[i+1]; hold[STAGES] = 0.
- Per edge, priority per stage: flush[i] -> valid=0, wr_en=0 (payload/rd kept). Else hold[i] -> keep. Else if i>0 and hold[i-1] -> bubble (valid=0, wr_en=0). Else load.
- Flush overrides stall. Stage 0 never bubbles; it loads when not held.
- Forward match for source s at stage j: valid & wr_en & rd==src & src!=0.
- Youngest matching stage wins, i.e. the lowest j.
- Match with j >= READY_STAGE: fwd_sel = j+1, fwd_data = payload[DW-1:0] of stage j.
- Match with j < READY_STAGE: hazard=1, fwd_sel=0. An older ready match is never used.
- Address 0 never matches. fwd_sel, fwd_data and hazard are combinational from stage registers and src_addr only.

## Timing
- Reset (rst=0 at edge): all valid, wr_en, rd and payload = 0. Outputs: stage_valid=0, out_*=0, fwd_sel=0, fwd_data=0, hazard=0 (src_addr ignored while all stages are invalid).
- Reset mid-operation discards all in-flight entries in the same edge.
- Latency in_valid -> out_valid: STAGES cycles with no holds.
- Throughput: one entry per cycle.
- A stall of k cycles on stage i delays all older-than-i... it holds stages 0..i for k cycles and inserts k bubbles into stage i+1.
- Simultaneous flush[i] & stall[i]: stage i becomes a bubble and still holds upstream (hold[i-1] is still 1).
- Writeback stage STAGES-1 remains forwardable in the same cycle it drives out_* (covers write-after-read on the same edge).

## Configuration
- PIPE_FWD_EN defined: forwarding as above.
- PIPE_FWD_EN undefined: fwd_sel=0 and fwd_data=0 always, and any match in any stage asserts hazard. The pipeline then waits for writeback to complete before reading.

## Structure
- Package pipe_pkg: default AW, the SELW computation function, and a stage_t struct typedef {valid, wr_en, rd}.
- One sub-module, pipe_stage_reg: a single stage with load/hold/bubble/flush priority. It is instantiated STAGES times in a generate loop.
- Forward/hazard logic is inline in the top module.

## Test plan
- Reset, then in_valid=1, rd=5, wr_en=1, payload=0xA5 with STAGES=3 -> out_valid=1, out_rd=5, out_payload=0xA5 exactly 3 cycles later; all outputs 0 during reset.
- rd=7 in stage 1, src_addr[0]=7 -> fwd_sel=2, fwd_data=stage-1 result.
- Add rd=7 also in stage 2 -> fwd_sel stays 2 (youngest wins).
- rd=7 in stage 0 (READY_STAGE=1), src=7 -> hazard=1.
- Next: stall[0] for 1 cycle -> stage 1 gets a bubble, then fwd_sel=2, hazard=0.
- src_addr=0 while rd=0 wr_en=1 in stage 1 -> fwd_sel=0, hazard=0.
- flush[1] & stall[1] same cycle -> stage_valid[1]=0 next cycle, and stage 0 holds its content.
- Build without PIPE_FWD_EN: rd=3 in stage 2, src=3 -> hazard=1, fwd_sel=0.
- Once the entry leaves stage 2 -> hazard=0.
